// File: rtl/pacman_pkg.sv
// Shared types and widths for the pacman score/lives keeper.
package pacman_pkg;

    typedef enum logic [1:0] {PLAY, INVULN, WON, LOST} keeper_state_t;

    localparam int LIVES_W      = 3;
    localparam int SCORE_DIGITS = 4;

endpackage

// File: rtl/bcd_counter_4d.sv
// Saturating decimal counter; clear wins over inc, holds at all nines.
module bcd_counter_4d
    import pacman_pkg::*;
(
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      clear,
    input  logic                      inc,
    output logic [4*SCORE_DIGITS-1:0] bcd
);

    localparam logic [4*SCORE_DIGITS-1:0] ALL_NINES = {SCORE_DIGITS{4'h9}};

    logic [4*SCORE_DIGITS-1:0] bcd_nx;
    logic                      carry;

    always_comb begin
        bcd_nx = bcd;
        carry  = inc && (bcd != ALL_NINES);
        // Ripple the +1 upward; a digit at 9 rolls to 0 and passes the carry on.
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (carry) begin
                if (bcd[4*i +: 4] == 4'd9) begin
                    bcd_nx[4*i +: 4] = 4'd0;
                end else begin
                    bcd_nx[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN || clear) bcd <= '0;
        else                  bcd <= bcd_nx;
    end

endmodule

// File: rtl/score_lives_keeper.sv
// Score, lives and win/lose tracking driven by the controller's hit pulses;
// also emits the respawn pulse and counts the post-death invulnerability window in frames.
module score_lives_keeper
    import pacman_pkg::*;
#(
    parameter int NUM_COINS     = 64,
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      SingleHitPulse_pc,
    input  logic                      SingleHitPulse_mp,
    input  logic                      stop_gameN,
    input  logic                      new_game,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [LIVES_W-1:0]        lives,
    output logic                      invuln,
    output logic                      respawn_pulse,
    output logic                      win_flag,
    output logic                      lose_flag
);

    localparam int COIN_W = $clog2(NUM_COINS + 1);
    localparam int INV_W  = $clog2(INVULN_FRAMES + 1);

    if (START_LIVES < 1 || START_LIVES > 7) begin : g_bad_lives
        $error("score_lives_keeper: START_LIVES must be in 1..7");
    end
    if (INVULN_FRAMES < 1) begin : g_bad_invuln
        $error("score_lives_keeper: INVULN_FRAMES must be >= 1");
    end

    keeper_state_t        state, state_nx;
    logic [COIN_W-1:0]    coins_left, coins_nx;
    logic [LIVES_W-1:0]   lives_nx;
    logic [INV_W-1:0]     invuln_cnt, invuln_nx;
    logic                 respawn_nx;
    logic                 score_inc, score_clr, last_coin;

    always_comb begin
        state_nx   = state;
        coins_nx   = coins_left;
        lives_nx   = lives;
        invuln_nx  = invuln_cnt;
        respawn_nx = 1'b0;
        score_inc  = 1'b0;
        score_clr  = 1'b0;
        last_coin  = 1'b0;
        case (state)
            PLAY, INVULN: begin
                if (stop_gameN) begin
                    // Coin is applied first; eating the last coin wins and drops any same-cycle hit.
                    if (SingleHitPulse_pc) begin
                        score_inc = 1'b1;
                        if (coins_left != '0) coins_nx = coins_left - 1'b1;
                        if (coins_left == COIN_W'(1)) begin
                            last_coin = 1'b1;
                            state_nx  = WON;
                        end
                    end
                    if (!last_coin) begin
                        if (state == PLAY && SingleHitPulse_mp) begin
                            if (lives <= LIVES_W'(1)) begin
                                lives_nx = '0;
                                state_nx = LOST;
                            end else begin
                                lives_nx   = lives - 1'b1;
                                state_nx   = INVULN;
                                invuln_nx  = INV_W'(INVULN_FRAMES);
                                respawn_nx = 1'b1;
                            end
                        end else if (state == INVULN && startOfFrame) begin
                            if (invuln_cnt != '0) invuln_nx = invuln_cnt - 1'b1;
                            if (invuln_cnt <= INV_W'(1)) state_nx = PLAY;
                        end
                    end
                end
            end
            WON, LOST: begin
                if (new_game) begin
                    score_clr = 1'b1;
                    state_nx  = PLAY;
                    coins_nx  = COIN_W'(NUM_COINS);
                    lives_nx  = LIVES_W'(START_LIVES);
                    invuln_nx = '0;
                end
            end
            default: state_nx = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state         <= PLAY;
            coins_left    <= COIN_W'(NUM_COINS);
            lives         <= LIVES_W'(START_LIVES);
            invuln_cnt    <= '0;
            respawn_pulse <= 1'b0;
            invuln        <= 1'b0;
            win_flag      <= 1'b0;
            lose_flag     <= 1'b0;
        end else begin
            state         <= state_nx;
            coins_left    <= coins_nx;
            lives         <= lives_nx;
            invuln_cnt    <= invuln_nx;
            respawn_pulse <= respawn_nx;
            invuln        <= (state_nx == INVULN);
            win_flag      <= (state_nx == WON);
            lose_flag     <= (state_nx == LOST);
        end
    end

    bcd_counter_4d u_score (
        .clk    (clk),
        .resetN (resetN),
        .clear  (score_clr),
        .inc    (score_inc),
        .bcd    (score_bcd)
    );

endmodule

// File: tb/tb_score_lives_keeper.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_score_lives_keeper;

    localparam int NC = 64;
    localparam int SL = 3;
    localparam int IF = 60;
    localparam int S_PLAY = 0, S_INV = 1, S_WON = 2, S_LOST = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN = 1'b0, sof = 1'b0, pc = 1'b0, mp = 1'b0, stop_gameN = 1'b1, new_game = 1'b0;
    logic [15:0] score_bcd;
    logic [2:0]  lives;
    logic        invuln, respawn_pulse, win_flag, lose_flag;

    logic        rst_b = 1'b0, pc_b = 1'b0;
    logic [15:0] score_b;
    logic [2:0]  lives_b;
    logic        inv_b, resp_b, win_b, lose_b;

    score_lives_keeper #(.NUM_COINS(NC), .START_LIVES(SL), .INVULN_FRAMES(IF)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .SingleHitPulse_pc(pc),
        .SingleHitPulse_mp(mp), .stop_gameN(stop_gameN), .new_game(new_game),
        .score_bcd(score_bcd), .lives(lives), .invuln(invuln), .respawn_pulse(respawn_pulse),
        .win_flag(win_flag), .lose_flag(lose_flag)
    );

    score_lives_keeper #(.NUM_COINS(10050), .START_LIVES(3), .INVULN_FRAMES(60)) dut_big (
        .clk(clk), .resetN(rst_b), .startOfFrame(1'b0), .SingleHitPulse_pc(pc_b),
        .SingleHitPulse_mp(1'b0), .stop_gameN(1'b1), .new_game(1'b0),
        .score_bcd(score_b), .lives(lives_b), .invuln(inv_b), .respawn_pulse(resp_b),
        .win_flag(win_b), .lose_flag(lose_b)
    );

    typedef struct {
        logic [15:0] score;
        logic [2:0]  lives;
        logic        inv, resp, win, lose;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0, n_fail = 0;

    // Reference model: plain integer game state.
    int m_score, m_lives, m_coins, m_inv, m_st, m_resp;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic reset_model();
        m_score = 0; m_lives = SL; m_coins = NC; m_inv = 0; m_st = S_PLAY; m_resp = 0;
    endtask

    task automatic model_step(input logic r, p, m, f, s, g);
        int pst;
        bit won;
        m_resp = 0;
        pst = m_st;
        if (!r) begin
            reset_model();
        end else if (pst == S_WON || pst == S_LOST) begin
            if (g) reset_model();
        end else if (s) begin
            won = 0;
            if (p) begin
                if (m_score < 9999) m_score++;
                if (m_coins == 1) won = 1;
                if (m_coins > 0) m_coins--;
                if (won) m_st = S_WON;
            end
            if (!won) begin
                if (pst == S_PLAY && m) begin
                    m_lives--;
                    if (m_lives == 0) m_st = S_LOST;
                    else begin m_st = S_INV; m_inv = IF; m_resp = 1; end
                end else if (pst == S_INV && f) begin
                    m_inv--;
                    if (m_inv == 0) m_st = S_PLAY;
                end
            end
        end
    endtask

    task automatic drive(input logic r, p, m, f, s, g, input string tag);
        exp_t e;
        @(negedge clk);
        resetN = r; pc = p; mp = m; sof = f; stop_gameN = s; new_game = g;
        model_step(r, p, m, f, s, g);
        e.score = to_bcd(m_score);
        e.lives = 3'(m_lives);
        e.inv   = (m_st == S_INV);
        e.resp  = (m_resp != 0);
        e.win   = (m_st == S_WON);
        e.lose  = (m_st == S_LOST);
        e.tag   = tag;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) drive(1, 0, 0, 0, 1, 0, tag);
    endtask

    task automatic coin(input int n, input string tag);
        repeat (n) begin drive(1, 1, 0, 0, 1, 0, tag); drive(1, 0, 0, 0, 1, 0, tag); end
    endtask

    // Frames every other cycle; optional mp attempts that must be ignored while invulnerable.
    task automatic frames(input int n, input bit try_mp, input string tag);
        for (int k = 0; k < n; k++) begin
            drive(1, 0, try_mp && (k % 3 == 0), 1, 1, 0, tag);
            drive(1, 0, 0, 0, 1, 0, tag);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            if (score_bcd !== e.score || lives !== e.lives || invuln !== e.inv ||
                respawn_pulse !== e.resp || win_flag !== e.win || lose_flag !== e.lose) begin
                n_fail++;
                $display("FAIL %s: got score=%h lives=%0d inv=%b resp=%b win=%b lose=%b, want score=%h lives=%0d inv=%b resp=%b win=%b lose=%b",
                         e.tag, score_bcd, lives, invuln, respawn_pulse, win_flag, lose_flag,
                         e.score, e.lives, e.inv, e.resp, e.win, e.lose);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic main_seq();
        reset_model();
        repeat (3) drive(0, 0, 0, 0, 1, 0, "reset");
        coin(12, "pc12");
        drive(1, 0, 1, 0, 1, 0, "mp_first");
        idle(2, "respawn_clear");
        frames(IF, 1, "invuln_window");
        idle(2, "invuln_done");
        repeat (6) drive(1, 1, 1, 1, 0, 0, "frozen_play");
        coin(47, "to_5_left");
        drive(1, 1, 1, 0, 1, 0, "pc_mp_5left");
        repeat (6) drive(1, 1, 1, 1, 0, 0, "frozen_invuln");
        frames(IF, 1, "invuln_window2");
        coin(3, "to_1_left");
        drive(1, 1, 1, 0, 1, 0, "pc_mp_last");
        drive(1, 1, 0, 0, 1, 0, "won_hold_pc");
        drive(1, 0, 1, 0, 1, 0, "won_hold_mp");
        drive(1, 0, 0, 0, 1, 1, "new_game_won");
        drive(1, 1, 0, 0, 1, 0, "pc_after_ng");
        drive(1, 0, 0, 0, 1, 1, "ng_in_play");
        drive(0, 0, 0, 0, 1, 0, "reset_midgame");
        repeat (64) drive(1, 1, 0, 0, 1, 0, "pc64");
        drive(1, 1, 1, 0, 1, 0, "won_hold");
        drive(1, 0, 0, 0, 1, 1, "new_game_won2");
        for (int d = 0; d < 3; d++) begin
            drive(1, 0, 1, 0, 1, 0, "mp_death");
            frames(IF + 1, 0, "between_deaths");
        end
        drive(1, 1, 1, 0, 1, 0, "lost_hold");
        drive(1, 0, 0, 0, 1, 1, "new_game_lost");
        idle(2, "after_lost_ng");
        for (int i = 0; i < 2500; i++)
            drive(($urandom % 400) != 0, ($urandom % 4) == 0, ($urandom % 12) == 0,
                  ($urandom % 3) == 0, ($urandom % 8) != 0, ($urandom % 50) == 0, "random");
        idle(2, "tail");
    endtask

    task automatic big_seq();
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (9999) begin @(negedge clk); pc_b = 1'b1; end
        @(posedge clk); #1;
        chk("big_9999", int'(score_b), 'h9999);
        @(negedge clk); pc_b = 1'b1;
        @(negedge clk); pc_b = 1'b0;
        @(posedge clk); #1;
        chk("big_saturate", int'(score_b), 'h9999);
        chk("big_lives", int'(lives_b), 3);
        chk("big_flags", int'({inv_b, resp_b, win_b, lose_b}), 0);
    endtask

    initial begin
        fork
            main_seq();
            big_seq();
        join
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
